// File: rtl/debounce_pkg.sv
// debounce_pkg: default parameters shared by the debounce array and its channels,
// plus the auto-repeat counter width helper (used when DEBOUNCE_REPEAT_EN is defined).
package debounce_pkg;

    localparam int CH_DEFAULT           = 4;
    localparam int DEPTH_DEFAULT        = 4;
    localparam int DIV_BITS_DEFAULT     = 19;
    localparam int REPEAT_TICKS_DEFAULT = 64;

    // Counter must be able to hold the value REPEAT_TICKS itself.
    function automatic int rpt_width(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_onepulse_array_channel.sv
// debounce_channel: one button channel. 2-flop synchroniser, DEPTH-bit sample
// shift register clocked by the shared tick, debounced level and one-cycle
// rise/fall pulses. Optional auto-repeat on rise (macro DEBOUNCE_REPEAT_EN).
// Ports: clk, rst_n (async, active low), tick (sample strobe), in (raw),
//        level (debounced), rise / fall (one-clk pulses).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DEPTH-1:0] sh_q, sh_d, sh_next;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = rpt_width(REPEAT_TICKS);
    logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
`endif

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        sh_next = {sh_q[DEPTH-2:0], sync2_q};
        sh_d    = sh_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
        rpt_d   = rpt_q;
        rpt_inc = rpt_q + 1'b1;
`endif
        if (tick) begin
            sh_d = sh_next;
            // Decide on the freshly shifted window, same edge.
            if ((&sh_next) && !level_q) begin
                level_d = 1'b1;
                rise_d  = 1'b1;
            end else if (~(|sh_next) && level_q) begin
                level_d = 1'b0;
                fall_d  = 1'b1;
            end
        end
`ifdef DEBOUNCE_REPEAT_EN
        // Counter only runs while the level is, and stays, high; this keeps
        // repeat pulses off the accept edge and off any fall.
        if (!level_q || !level_d) begin
            rpt_d = '0;
        end else if (tick) begin
            if (rpt_inc == RW'(REPEAT_TICKS)) begin
                rise_d = 1'b1;
                rpt_d  = '0;
            end else begin
                rpt_d = rpt_inc;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sh_q    <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sh_q    <= sh_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/debounce_onepulse_array.sv
// debounce_onepulse_array: CH-channel push-button conditioner. Shared prescaler
// produces a one-clk sample tick every 2^DIV_BITS clocks; each channel is a
// debounce_channel. Optional auto-repeat: define DEBOUNCE_REPEAT_EN.
// Ports: clk, rst_n (async, active low), in[CH] (raw), level[CH],
//        rise[CH], fall[CH] (one-clk pulses), tick (sample strobe).
module debounce_onepulse_array
    import debounce_pkg::*;
#(
    parameter int CH           = CH_DEFAULT,
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int DIV_BITS     = DIV_BITS_DEFAULT,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          tick
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is the all-ones counter state; zero in reset since cnt_q clears.
    assign tick = &cnt_q;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        debounce_channel #(
            .DEPTH       (DEPTH),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .in   (in[g]),
            .level(level[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

endmodule

// File: tb/tb_debounce_onepulse_array.sv
// tb_debounce_onepulse_array: directed self-checking bench, CH=4 DEPTH=4
// DIV_BITS=2 REPEAT_TICKS=3. Repeat expectations follow DEBOUNCE_REPEAT_EN.
`timescale 1ns/1ps
module tb_debounce_onepulse_array;

    logic       clk;
    logic       rst_n;
    logic [3:0] in;
    logic [3:0] level, rise, fall;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc;
    int rc[4], fc[4], rise1[4], fall1[4], up1[4], dn1[4];
    int both_cnt;
    int rise2_at[8];

    debounce_onepulse_array #(
        .CH(4), .DEPTH(4), .DIV_BITS(2), .REPEAT_TICKS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in),
        .level(level), .rise(rise), .fall(fall), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_obs();
        cyc = 0;
        both_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            rc[c] = 0; fc[c] = 0;
            rise1[c] = -1; fall1[c] = -1;
            up1[c] = -1; dn1[c] = -1;
        end
        for (int k = 0; k < 8; k++) rise2_at[k] = -1;
    endtask

    // Sample #1 after each rising edge; cycle index counts edges since clear.
    task automatic observe(input int n);
        logic [3:0] prev;
        prev = level;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < 4; c++) begin
                if (rise[c]) begin
                    rc[c]++;
                    if (rise1[c] < 0) rise1[c] = cyc;
                    if (c == 2 && rc[c] <= 8) rise2_at[rc[c]-1] = cyc;
                end
                if (fall[c]) begin
                    fc[c]++;
                    if (fall1[c] < 0) fall1[c] = cyc;
                end
                if (rise[c] && fall[c]) both_cnt++;
                if (level[c] && !prev[c] && up1[c] < 0) up1[c] = cyc;
                if (!level[c] && prev[c] && dn1[c] < 0) dn1[c] = cyc;
            end
            prev = level;
        end
    endtask

    task automatic do_reset(input logic [3:0] v);
        rst_n = 1'b0;
        in = v;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({level, rise, fall, tick} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected 0",
                         {level, rise, fall, tick});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_cycle0: got %b expected 0", tick);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (tick !== ((k % 4) == 3)) begin
                n_fail++;
                $display("FAIL tick_cycle%0d: got %b expected %b",
                         k, tick, (k % 4) == 3);
            end
        end
        clear_obs();
        observe(20);
        n_checks++;
        if (level !== 4'b1111) begin
            n_fail++;
            $display("FAIL held_level: got %b expected 1111", level);
        end
        n_checks++;
        if (rise1[0] < 1 || rise1[0] !== up1[0]) begin
            n_fail++;
            $display("FAIL held_rise: got rise at %0d expected level edge %0d",
                     rise1[0], up1[0]);
        end
    endtask

    task automatic test_clean_press();
        do_reset(4'b0000);
        @(posedge clk);
        #1;
        in[0] = 1'b1;
        clear_obs();
        observe(20);
        n_checks++;
        if (up1[0] < 1 || up1[0] > 18) begin
            n_fail++;
            $display("FAIL press_latency: got %0d expected 1..18", up1[0]);
        end
        n_checks++;
        if (rise1[0] !== up1[0]) begin
            n_fail++;
            $display("FAIL press_coincident: got %0d expected %0d",
                     rise1[0], up1[0]);
        end
        n_checks++;
        if (rc[0] !== 1) begin
            n_fail++;
            $display("FAIL press_rise_count: got %0d expected 1", rc[0]);
        end
        n_checks++;
        if ((rc[1] + rc[2] + rc[3] + fc[0] + fc[1] + fc[2] + fc[3]) !== 0) begin
            n_fail++;
            $display("FAIL press_others: got %0d expected 0",
                     rc[1] + rc[2] + rc[3] + fc[1] + fc[2] + fc[3] + fc[0]);
        end
    endtask

    task automatic test_glitch();
        in[1] = 1'b1;
        clear_obs();
        observe(12);
        in[1] = 1'b0;
        observe(30);
        n_checks++;
        if (up1[1] !== -1 || rc[1] !== 0 || fc[1] !== 0) begin
            n_fail++;
            $display("FAIL glitch_ch1: got up=%0d rise=%0d fall=%0d expected -1 0 0",
                     up1[1], rc[1], fc[1]);
        end
        n_checks++;
        if (level !== 4'b0001) begin
            n_fail++;
            $display("FAIL glitch_level: got %b expected 0001", level);
        end
    endtask

    task automatic test_release();
        in[0] = 1'b0;
        clear_obs();
        observe(20);
        n_checks++;
        if (dn1[0] < 1 || dn1[0] > 18 || fall1[0] !== dn1[0]) begin
            n_fail++;
            $display("FAIL release_fall: got fall=%0d dn=%0d expected equal in 1..18",
                     fall1[0], dn1[0]);
        end
        n_checks++;
        if (fc[0] !== 1 || level[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_once: got fc=%0d lvl=%b expected 1 0",
                     fc[0], level[0]);
        end
        n_checks++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL release_both: got %0d expected 0", both_cnt);
        end
`ifndef DEBOUNCE_REPEAT_EN
        n_checks++;
        if (rc[0] !== 0) begin
            n_fail++;
            $display("FAIL release_no_rise: got %0d expected 0", rc[0]);
        end
`endif
    endtask

    task automatic test_simultaneous();
        in = 4'b1111;
        clear_obs();
        observe(20);
        n_checks++;
        if (rise1[0] < 1 || rise1[1] !== rise1[0] ||
            rise1[2] !== rise1[0] || rise1[3] !== rise1[0]) begin
            n_fail++;
            $display("FAIL simul_rise: got %0d %0d %0d %0d expected equal",
                     rise1[0], rise1[1], rise1[2], rise1[3]);
        end
        n_checks++;
        if (up1[3] !== rise1[0] || level !== 4'b1111) begin
            n_fail++;
            $display("FAIL simul_level: got up=%0d lvl=%b expected %0d 1111",
                     up1[3], level, rise1[0]);
        end
    endtask

    task automatic test_repeat_reset();
        int exp_rc;
        do_reset(4'b0000);
        @(posedge clk);
        #1;
        in[2] = 1'b1;
        clear_obs();
        observe(60);
`ifdef DEBOUNCE_REPEAT_EN
        exp_rc = 1 + (60 - rise1[2]) / 12;
        n_checks++;
        if (rise2_at[1] - rise2_at[0] !== 12) begin
            n_fail++;
            $display("FAIL repeat_period: got %0d expected 12",
                     rise2_at[1] - rise2_at[0]);
        end
`else
        exp_rc = 1;
`endif
        n_checks++;
        if (rc[2] !== exp_rc || rise1[2] !== up1[2]) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d expected %0d", rc[2], exp_rc);
        end
        n_checks++;
        if (fc[2] !== 0 || level !== 4'b0100) begin
            n_fail++;
            $display("FAIL repeat_hold: got fc=%0d lvl=%b expected 0 0100",
                     fc[2], level);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({level, rise, fall, tick} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0",
                     {level, rise, fall, tick});
        end
        clear_obs();
        observe(5);
        in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        observe(20);
        n_checks++;
        if (fc[2] !== 0 || level !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_fall: got fc=%0d lvl=%b expected 0 0000",
                     fc[2], level);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in = 4'b0000;
        test_reset();
        test_clean_press();
        test_glitch();
        test_release();
        test_simultaneous();
        test_repeat_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
